// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one two-cycle registered ALU among NREQ
// requesters, returning each result to its owner over a valid/ready handshake.
module alu_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DATAW   = 16,
  parameter int unsigned OPS     = 4,
  parameter int unsigned OPCODEW = $clog2(OPS),
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*OPCODEW-1:0] req_opcode,
  input  logic [NREQ*DATAW-1:0]   req_dataa,
  input  logic [NREQ*DATAW-1:0]   req_datab,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [DATAW-1:0]        rsp_result,
  output logic [IDW-1:0]          rsp_id,
  output logic [OPCODEW-1:0]      alu_opcode,
  output logic [DATAW-1:0]        alu_dataa,
  output logic [DATAW-1:0]        alu_datab,
  input  logic [DATAW-1:0]        alu_result,
  output logic                    busy,
  output logic [15:0]             op_count
);

  typedef enum logic [2:0] {StIdle, StIssue, StHold, StCapt, StResp} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      last_grant_q;
  logic [IDW-1:0]      id_q;
  logic [OPCODEW-1:0]  op_q;
  logic [DATAW-1:0]    a_q, b_q, result_q;
  logic [15:0]         count_q;
  logic                busy_q;

  logic [OPCODEW-1:0]  op_arr [NREQ];
  logic [DATAW-1:0]    a_arr  [NREQ];
  logic [DATAW-1:0]    b_arr  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i] = req_opcode[i*OPCODEW +: OPCODEW];
    assign a_arr[i]  = req_dataa[i*DATAW +: DATAW];
    assign b_arr[i]  = req_datab[i*DATAW +: DATAW];
  end

  logic [IDW-1:0] grant_id, cand;
  logic           grant_found;
  logic           accept, resp_done;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_id    = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_grant_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign accept    = (state_q == StIdle) && grant_found;
  assign resp_done = (state_q == StResp) && rsp_ready[id_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StHold;
      StHold:  state_d = StCapt;
      StCapt:  state_d = StResp;
      StResp:  if (resp_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (grant_id == IDW'(i));
      rsp_valid[i] = (state_q == StResp) && (id_q == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      if (accept) begin
        op_q         <= op_arr[grant_id];
        a_q          <= a_arr[grant_id];
        b_q          <= b_arr[grant_id];
        id_q         <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == StCapt) result_q <= alu_result;
      if (resp_done) count_q <= count_q + 16'd1;
    end
  end

  assign alu_opcode = op_q;
  assign alu_dataa  = a_q;
  assign alu_datab  = b_q;
  assign rsp_result = result_q;
  assign rsp_id     = id_q;
  assign busy       = busy_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a two-cycle registered ALU model on the alu_* side.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]  req_opcode;
  logic [63:0] req_dataa, req_datab;
  logic [15:0] rsp_result, alu_dataa, alu_datab, alu_result, op_count;
  logic [1:0]  rsp_id, alu_opcode;
  logic        busy;

  logic [1:0]  op_v [4];
  logic [15:0] a_v  [4];
  logic [15:0] b_v  [4];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign req_opcode[i*2 +: 2] = op_v[i];
    assign req_dataa[i*16 +: 16] = a_v[i];
    assign req_datab[i*16 +: 16] = b_v[i];
  end

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_dataa  (req_dataa),
    .req_datab  (req_datab),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .alu_opcode (alu_opcode),
    .alu_dataa  (alu_dataa),
    .alu_datab  (alu_datab),
    .alu_result (alu_result),
    .busy       (busy),
    .op_count   (op_count)
  );

  // ALU model: operands registered at end of ISSUE, opcode-selected result at end of HOLD.
  logic [15:0] s1a, s1b;
  logic [31:0] prod;
  assign prod = 32'(s1a) * 32'(s1b);
  always @(posedge clk) begin
    s1a <= alu_dataa;
    s1b <= alu_datab;
    case (alu_opcode)
      2'd0:    alu_result <= s1a + s1b;
      2'd1:    alu_result <= s1a - s1b;
      2'd2:    alu_result <= s1b - s1a;
      default: alu_result <= prod[15:0];
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after an edge with the DUT idle; leaves it idle again.
  task automatic run_op(input logic [1:0] id, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp, input string tag);
    logic [3:0] oh;
    oh = 4'(1) << id;
    op_v[id]  = op;
    a_v[id]   = a;
    b_v[id]   = b;
    req_valid = oh;
    rsp_ready = '0;
    #1 chk({tag, " ready"}, 32'(req_ready), 32'(oh));
    tick();
    req_valid = '0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    tick();
    tick();
    chk({tag, " no early rsp"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(oh));
    chk({tag, " result"}, 32'(rsp_result), 32'(exp));
    chk({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
    rsp_ready = oh;
    tick();
    rsp_ready = '0;
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int         k;
    int         last_c;
    logic [1:0] exp_g;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < 4; i++) begin
      op_v[i] = '0;
      a_v[i]  = '0;
      b_v[i]  = '0;
    end

    #12;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset op_count", 32'(op_count), 32'd0);
    chk("reset alu_dataa", 32'(alu_dataa), 32'd0);
    chk("reset rsp_result", 32'(rsp_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(2'd0, 2'd0, 16'd5, 16'd3, 16'd8, "add");
    chk("add op_count", 32'(op_count), 32'd1);
    run_op(2'd2, 2'd3, 16'd300, 16'd300, 16'h5F90, "mul wrap");
    run_op(2'd1, 2'd2, 16'd5, 16'd3, 16'hFFFE, "b-a wrap");
    chk("wrap op_count", 32'(op_count), 32'd3);
    chk("alu_dataa held", 32'(alu_dataa), 32'd5);

    // Backpressure: owner withholds rsp_ready, others assert theirs.
    op_v[3] = 2'd1; a_v[3] = 16'd10; b_v[3] = 16'd4;
    req_valid = 4'b1000;
    #1 chk("bp ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0001;
    rsp_ready = 4'b0111;
    tick();
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp rsp_valid", 32'(rsp_valid), 32'b1000);
      chk("bp result", 32'(rsp_result), 32'd6);
      chk("bp rsp_id", 32'(rsp_id), 32'd3);
      chk("bp req_ready", 32'(req_ready), 32'd0);
      chk("bp op_count", 32'(op_count), 32'd3);
      tick();
    end
    req_valid = '0;
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = '0;
    chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp release busy", 32'(busy), 32'd0);
    chk("bp op_count", 32'(op_count), 32'd4);

    // Requester changes its inputs after acceptance.
    op_v[0] = 2'd0; a_v[0] = 16'd7; b_v[0] = 16'd2;
    req_valid = 4'b0001;
    #1 chk("chg ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    op_v[0] = 2'd3;
    a_v[0]  = 16'd9;
    chk("chg issue opcode", 32'(alu_opcode), 32'd0);
    chk("chg issue dataa", 32'(alu_dataa), 32'd7);
    tick();
    chk("chg hold opcode", 32'(alu_opcode), 32'd0);
    chk("chg hold dataa", 32'(alu_dataa), 32'd7);
    tick();
    tick();
    chk("chg result", 32'(rsp_result), 32'd9);
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    chk("chg op_count", 32'(op_count), 32'd5);

    // Reset during HOLD drops the operation.
    op_v[1] = 2'd0; a_v[1] = 16'd1; b_v[1] = 16'd1;
    req_valid = 4'b0010;
    #1 chk("rst ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst alu_dataa", 32'(alu_dataa), 32'd0);
    chk("rst rsp_result", 32'(rsp_result), 32'd0);
    chk("rst op_count", 32'(op_count), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    op_v[0] = 2'd0; a_v[0] = 16'd30; b_v[0] = 16'd2;
    op_v[2] = 2'd0; a_v[2] = 16'd20; b_v[2] = 16'd1;
    req_valid = 4'b0101;
    #1 chk("post-rst priority", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0100;
    tick();
    tick();
    chk("post-rst capt ready", 32'(req_ready), 32'd0);
    chk("post-rst capt rsp", 32'(rsp_valid), 32'd0);
    tick();
    chk("post-rst rsp_valid", 32'(rsp_valid), 32'b0001);
    chk("post-rst result", 32'(rsp_result), 32'd32);
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    chk("post-rst next grant", 32'(req_ready), 32'b0100);
    req_valid = '0;

    // Round-robin fairness from a fresh reset.
    tick();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_v[i] = 2'd0;
      a_v[i]  = 16'(i + 1);
      b_v[i]  = 16'd10;
    end
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    #1;
    k = 0;
    last_c = 0;
    for (int c = 0; c < 30; c++) begin
      chk("rr one ready", 32'($countones(req_ready) <= 1), 32'd1);
      if (req_ready != 4'd0) begin
        exp_g = 2'(k % 4);
        chk("rr grant", 32'(req_ready), 32'(4'(1) << exp_g));
        if (k > 0) chk("rr interval", 32'(c - last_c), 32'd5);
        last_c = c;
        k++;
      end
      if (rsp_valid != 4'd0) begin
        exp_g = 2'((k - 1) % 4);
        chk("rr rsp_id", 32'(rsp_id), 32'(exp_g));
        chk("rr result", 32'(rsp_result), 32'(11 + int'(exp_g)));
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = '0;
    chk("rr accepts", 32'(k), 32'd6);
    chk("rr op_count", 32'(op_count), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
